// File: rtl/branch_resolver.sv
// Four-stage branch resolver for a barrel-threaded pipeline: PC match, condition
// evaluation against ALU flags, registered taken/target, and per-thread taken counters.
module branch_resolver #(
   parameter int PC_WIDTH     = 10,
   parameter int COND_WIDTH   = 3,
   parameter int LINK_WIDTH   = 10,
   parameter int THREAD_COUNT = 8,
   parameter int THREAD_WIDTH = 3,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_valid,
   input  logic [THREAD_WIDTH-1:0] in_thread,
   input  logic [PC_WIDTH-1:0]     in_PC,
   input  logic [PC_WIDTH-1:0]     PC_match,
   input  logic [COND_WIDTH-1:0]   branch_condition,
   input  logic [2:0]              flags,
   input  logic [LINK_WIDTH-1:0]   BBC_link,
   output logic                    out_valid,
   output logic [THREAD_WIDTH-1:0] out_thread,
   output logic                    branch_taken,
   output logic [LINK_WIDTH-1:0]   branch_target,
   input  logic                    count_clear,
   input  logic [THREAD_WIDTH-1:0] count_clear_thread,
   input  logic [THREAD_WIDTH-1:0] count_read_thread,
   output logic [COUNT_WIDTH-1:0]  count_read_value
);

   // flags = {A_negative, A_zero, B_zero}
   function automatic logic eval_cond(input logic [COND_WIDTH-1:0] c, input logic [2:0] f);
      logic r;
      case (c)
         COND_WIDTH'(0): r = 1'b0;
         COND_WIDTH'(1): r = 1'b1;
         COND_WIDTH'(2): r = f[1];
         COND_WIDTH'(3): r = ~f[1];
         COND_WIDTH'(4): r = f[2];
         COND_WIDTH'(5): r = ~f[2];
         COND_WIDTH'(6): r = f[0];
         COND_WIDTH'(7): r = ~f[0];
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

   logic                    v1_q, v1_d, hit1_q, hit1_d;
   logic [THREAD_WIDTH-1:0] t1_q, t1_d;
   logic                    v2_q, v2_d, hit2_q, hit2_d;
   logic [THREAD_WIDTH-1:0] t2_q, t2_d;
   logic [COND_WIDTH-1:0]   cond2_q, cond2_d;
   logic                    v3_q, v3_d, take3_q, take3_d;
   logic [THREAD_WIDTH-1:0] t3_q, t3_d;
   logic                    out_valid_q, out_valid_d, branch_taken_q, branch_taken_d;
   logic [THREAD_WIDTH-1:0] out_thread_q, out_thread_d;
   logic [LINK_WIDTH-1:0]   branch_target_q, branch_target_d;
   logic [COUNT_WIDTH-1:0]  cnt_q [THREAD_COUNT];
   logic [COUNT_WIDTH-1:0]  cnt_d [THREAD_COUNT];

   always_comb begin
      v1_d            = in_valid;
      t1_d            = in_thread;
      hit1_d          = (in_PC == PC_match);
      v2_d            = v1_q;
      t2_d            = t1_q;
      hit2_d          = hit1_q;
      cond2_d         = branch_condition;
      v3_d            = v2_q;
      t3_d            = t2_q;
      take3_d         = v2_q & hit2_q & eval_cond(cond2_q, flags);
      out_valid_d     = v3_q;
      out_thread_d    = t3_q;
      branch_taken_d  = take3_q;
      branch_target_d = take3_q ? BBC_link : '0;
   end

   // A clear of the same thread overrides a coincident increment.
   always_comb begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (take3_q && (32'(t3_q) == i) && (cnt_q[i] != '1))
            cnt_d[i] = cnt_q[i] + 1'b1;
         if (count_clear && (32'(count_clear_thread) == i))
            cnt_d[i] = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v1_q            <= 1'b0;
         t1_q            <= '0;
         hit1_q          <= 1'b0;
         v2_q            <= 1'b0;
         t2_q            <= '0;
         hit2_q          <= 1'b0;
         cond2_q         <= '0;
         v3_q            <= 1'b0;
         t3_q            <= '0;
         take3_q         <= 1'b0;
         out_valid_q     <= 1'b0;
         out_thread_q    <= '0;
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
         for (int i = 0; i < THREAD_COUNT; i++) cnt_q[i] <= '0;
      end else begin
         v1_q            <= v1_d;
         t1_q            <= t1_d;
         hit1_q          <= hit1_d;
         v2_q            <= v2_d;
         t2_q            <= t2_d;
         hit2_q          <= hit2_d;
         cond2_q         <= cond2_d;
         v3_q            <= v3_d;
         t3_q            <= t3_d;
         take3_q         <= take3_d;
         out_valid_q     <= out_valid_d;
         out_thread_q    <= out_thread_d;
         branch_taken_q  <= branch_taken_d;
         branch_target_q <= branch_target_d;
         for (int i = 0; i < THREAD_COUNT; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign out_valid     = out_valid_q;
   assign out_thread    = out_thread_q;
   assign branch_taken  = branch_taken_q;
   assign branch_target = branch_target_q;

   // Out-of-range thread ids read as zero.
   always_comb begin
      count_read_value = '0;
      if (32'(count_read_thread) < THREAD_COUNT)
         count_read_value = cnt_q[count_read_thread];
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized scoreboard bench for branch_resolver: a driver issues slots with their
// staggered operands, a monitor pops expected decisions as outputs appear.
module tb_branch_resolver;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [2:0]  in_thread;
   logic [9:0]  in_PC, PC_match;
   logic [2:0]  branch_condition;
   logic [2:0]  flags;
   logic [9:0]  BBC_link;
   logic        out_valid;
   logic [2:0]  out_thread;
   logic        branch_taken;
   logic [9:0]  branch_target;
   logic        count_clear;
   logic [2:0]  count_clear_thread;
   logic [2:0]  count_read_thread;
   logic [15:0] count_read_value;

   branch_resolver dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_thread(in_thread),
      .in_PC(in_PC), .PC_match(PC_match), .branch_condition(branch_condition),
      .flags(flags), .BBC_link(BBC_link), .out_valid(out_valid), .out_thread(out_thread),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .count_clear(count_clear), .count_clear_thread(count_clear_thread),
      .count_read_thread(count_read_thread), .count_read_value(count_read_value)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       v;
      logic [2:0] t;
      logic [9:0] pc;
      logic [9:0] match;
      logic [2:0] cond;
      logic [2:0] flags;
      logic [9:0] link;
   } slot_t;

   // {due cycle, thread, taken, target}
   localparam int W = 32 + 3 + 1 + 10;
   logic [W-1:0] exp_q[$];
   slot_t        hist[4];
   int unsigned  mcnt[8];
   int unsigned  cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference decision: a truth table over the eight condition codes.
   function automatic logic ref_take(input slot_t s);
      logic [7:0] truth;
      logic a_neg, a_zero, b_zero;
      {a_neg, a_zero, b_zero} = s.flags;
      truth = {~b_zero, b_zero, ~a_neg, a_neg, ~a_zero, a_zero, 1'b1, 1'b0};
      return s.v && (s.pc == s.match) && truth[s.cond];
   endfunction

   function automatic slot_t rand_slot(input logic v);
      slot_t s;
      s.v     = v;
      s.t     = 3'($urandom_range(0, 7));
      s.pc    = 10'($urandom_range(0, 1023));
      s.match = ($urandom_range(0, 1) == 1) ? s.pc : 10'($urandom_range(0, 1023));
      s.cond  = 3'($urandom_range(0, 7));
      s.flags = 3'($urandom_range(0, 7));
      s.link  = 10'($urandom_range(0, 1023));
      return s;
   endfunction

   function automatic slot_t mk(input logic [2:0] t, input logic [9:0] pc, input logic [9:0] m,
                                input logic [2:0] c, input logic [2:0] f, input logic [9:0] l);
      slot_t s;
      s.v = 1'b1; s.t = t; s.pc = pc; s.match = m; s.cond = c; s.flags = f; s.link = l;
      return s;
   endfunction

   // One cycle: slot s enters; older slots get their condition, flags, link.
   task automatic step(input slot_t s, input logic clr = 1'b0, input logic [2:0] clr_t = 3'd0);
      logic take;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
      in_valid           = s.v;
      in_thread          = s.t;
      in_PC              = s.pc;
      PC_match           = s.match;
      branch_condition   = hist[1].cond;
      flags              = hist[2].flags;
      BBC_link           = hist[3].link;
      count_clear        = clr;
      count_clear_thread = clr_t;
      if (s.v) begin
         take = ref_take(s);
         exp_q.push_back({32'(cyc + 4), s.t, take, take ? s.link : 10'd0});
         if (take && mcnt[s.t] < 32'hFFFF) mcnt[s.t]++;
      end
      if (clr) mcnt[clr_t] = 0;
      @(posedge clock); #1;
      count_clear = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 5; i++) step(rand_slot(1'b0));
   endtask

   task automatic check_counts(input string name);
      for (int i = 0; i < 8; i++) begin
         count_read_thread = 3'(i);
         #0.1;
         check($sformatf("%s_cnt%0d", name, i), 64'(count_read_value), 64'(mcnt[i]));
      end
   endtask

   // Monitor: every presented decision must match the oldest expectation on time.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clock);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(out_thread), 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("out_cycle",  64'(cyc),            64'(e[W-1:14]));
               check("out_thread", 64'(out_thread),     64'(e[13:11]));
               check("out_taken",  64'(branch_taken),   64'(e[10]));
               check("out_target", 64'(branch_target),  64'(e[9:0]));
            end
         end else begin
            check("bubble_taken", 64'(branch_taken), 64'd0);
         end
      end
   end

   initial begin
      slot_t s;
      for (int i = 0; i < 4; i++) hist[i] = rand_slot(1'b0);
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      reset_n = 1'b0;
      in_valid = 1'b0; in_thread = '0; in_PC = '0; PC_match = '0;
      branch_condition = '0; flags = '0; BBC_link = '0;
      count_clear = 1'b0; count_clear_thread = '0; count_read_thread = '0;
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_taken",     64'(branch_taken), 64'd0);
      check("rst_thread",    64'(out_thread), 64'd0);
      check("rst_target",    64'(branch_target), 64'd0);
      check_counts("rst");
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // Basic hit and miss
      step(mk(3'd0, 10'h010, 10'h010, 3'd1, 3'd0, 10'h200));
      step(mk(3'd1, 10'h010, 10'h011, 3'd1, 3'd0, 10'h155));
      drain();
      check_counts("basic");

      // Condition sweep against A_zero only
      for (int c = 0; c < 8; c++) step(mk(3'd2, 10'h0AA, 10'h0AA, 3'(c), 3'b010, 10'(10'h300 + c)));
      drain();
      check_counts("sweep");

      // Eight threads back-to-back, alternating hit/miss
      for (int t = 0; t < 8; t++)
         step(mk(3'(t), 10'(t * 3), (t % 2 == 0) ? 10'(t * 3) : 10'(t * 3 + 1), 3'd1, 3'd0, 10'(t + 10'h40)));
      drain();
      check_counts("threads");

      // Random traffic
      for (int i = 0; i < 400; i++) step(rand_slot($urandom_range(0, 3) != 0));
      drain();
      check_counts("random");

      // Saturation on thread 3
      step(rand_slot(1'b0), 1'b1, 3'd3);
      for (int i = 0; i < 16'hFFFE; i++) step(mk(3'd3, 10'h123, 10'h123, 3'd1, 3'd0, 10'h3C3));
      drain();
      check_counts("preload");
      for (int i = 0; i < 3; i++) step(mk(3'd3, 10'h123, 10'h123, 3'd1, 3'd0, 10'h3C3));
      drain();
      check_counts("saturate");
      step(mk(3'd3, 10'h050, 10'h050, 3'd1, 3'd0, 10'h011));
      step(rand_slot(1'b0));
      step(rand_slot(1'b0));
      step(rand_slot(1'b0), 1'b1, 3'd3);
      drain();
      check_counts("clear_wins");

      // Reset with three decisions in flight
      for (int t = 0; t < 3; t++) step(mk(3'(t), 10'h077, 10'h077, 3'd1, 3'd0, 10'h2F0));
      reset_n = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      for (int i = 0; i < 4; i++) hist[i] = rand_slot(1'b0);
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(rand_slot(1'b0));
         check($sformatf("postrst_valid%0d", i), 64'(out_valid), 64'd0);
      end
      check_counts("postrst");
      step(mk(3'd5, 10'h001, 10'h001, 3'd7, 3'd0, 10'h0EE));
      drain();
      check_counts("final");
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
